// File: rtl/cac_decoder_7_seq_pkg.sv
// Shared constants for the 7-wire FNS crosstalk-avoidance decoder: Fibonacci
// weight widths, accumulator sizing and the decoder state encoding.
package cac_decoder_7_seq_pkg;

    localparam int BLEN_07   = 5;
    localparam int FNSLEN_02 = 1;
    localparam int FNSLEN_03 = 2;
    localparam int FNSLEN_04 = 2;
    localparam int FNSLEN_05 = 3;
    localparam int FNSLEN_06 = 4;
    localparam int FNSLEN_07 = 4;
    localparam int FNSLEN_08 = 5;

    // One spare bit so that the all-ones codeword cannot wrap the sum.
    localparam int ACC_W = FNSLEN_08 + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } dec_state_e;

    function automatic logic acc_ovf(input logic [ACC_W-1:0] acc);
        return |acc[ACC_W-1:BLEN_07];
    endfunction

endpackage

// File: rtl/cac_decoder_7_seq_weight_sel.sv
// Combinational Fibonacci weight selector: maps a codeword bit index to its
// weight, zero-extended to accumulator width.
module fns_weight_sel_7
    import cac_decoder_7_seq_pkg::*;
(
    input  logic [2:0]           idx,
    input  logic [FNSLEN_02-1:0] FNS02,
    input  logic [FNSLEN_03-1:0] FNS03,
    input  logic [FNSLEN_04-1:0] FNS04,
    input  logic [FNSLEN_05-1:0] FNS05,
    input  logic [FNSLEN_06-1:0] FNS06,
    input  logic [FNSLEN_07-1:0] FNS07,
    output logic [ACC_W-1:0]     weight
);

    // Weight lookup; bit 0 always carries weight 1.
    always_comb begin
        weight = {ACC_W{1'b0}};
        case (idx)
            3'd6:    weight = {{(ACC_W-FNSLEN_07){1'b0}}, FNS07};
            3'd5:    weight = {{(ACC_W-FNSLEN_06){1'b0}}, FNS06};
            3'd4:    weight = {{(ACC_W-FNSLEN_05){1'b0}}, FNS05};
            3'd3:    weight = {{(ACC_W-FNSLEN_04){1'b0}}, FNS04};
            3'd2:    weight = {{(ACC_W-FNSLEN_03){1'b0}}, FNS03};
            3'd1:    weight = {{(ACC_W-FNSLEN_02){1'b0}}, FNS02};
            3'd0:    weight = {{(ACC_W-1){1'b0}}, 1'b1};
            default: weight = {ACC_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/cac_decoder_7_seq.sv
// Sequential 7-wire FNS CAC decoder: accepts a codeword, sums its Fibonacci
// weights one bit per cycle MSB first, and holds the result until taken.
module cac_decoder_7_seq
    import cac_decoder_7_seq_pkg::*;
#(
    parameter int NBIT = 7
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [NBIT-1:0]      code_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FNSLEN_02-1:0] FNS02,
    input  logic [FNSLEN_03-1:0] FNS03,
    input  logic [FNSLEN_04-1:0] FNS04,
    input  logic [FNSLEN_05-1:0] FNS05,
    input  logic [FNSLEN_06-1:0] FNS06,
    input  logic [FNSLEN_07-1:0] FNS07,
    output logic [BLEN_07-1:0]   data_out,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [2:0] IDX_START = 3'(NBIT - 1);

    dec_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [2:0]        idx_q, idx_d;
    logic [NBIT-1:0]   code_q, code_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  weight_s;

    fns_weight_sel_7 u_weight_sel (
        .idx    (idx_q),
        .FNS02  (FNS02),
        .FNS03  (FNS03),
        .FNS04  (FNS04),
        .FNS05  (FNS05),
        .FNS06  (FNS06),
        .FNS07  (FNS07),
        .weight (weight_s)
    );

    // Next-state, accumulation and registered-output decode.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    code_d  = code_in;
                    acc_d   = {ACC_W{1'b0}};
                    idx_d   = IDX_START;
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                acc_d = acc_q + (code_q[idx_q] ? weight_s : {ACC_W{1'b0}});
                if (idx_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake flags follow the next state so both are true flops.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        ovf_d       = acc_ovf(acc_d);
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= {ACC_W{1'b0}};
            idx_q       <= 3'd0;
            code_q      <= {NBIT{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            code_q      <= code_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = acc_q[BLEN_07-1:0];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cac_decoder_7_seq.sv
// Directed, table-driven bench for the 7-wire FNS CAC decoder.
module tb_cac_decoder_7_seq;
    import cac_decoder_7_seq_pkg::*;

    logic                 clock = 1'b0;
    logic                 rst_n;
    logic [6:0]           code_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [FNSLEN_02-1:0] fns02;
    logic [FNSLEN_03-1:0] fns03;
    logic [FNSLEN_04-1:0] fns04;
    logic [FNSLEN_05-1:0] fns05;
    logic [FNSLEN_06-1:0] fns06;
    logic [FNSLEN_07-1:0] fns07;
    logic [BLEN_07-1:0]   data_out;
    logic                 ovf;
    logic                 out_valid;
    logic                 out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [6:0] code;
        logic [4:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl [0:22];

    always #5 clock = ~clock;

    cac_decoder_7_seq #(.NBIT(7)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .code_in   (code_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .FNS02     (fns02),
        .FNS03     (fns03),
        .FNS04     (fns04),
        .FNS05     (fns05),
        .FNS06     (fns06),
        .FNS07     (fns07),
        .data_out  (data_out),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Greedy MSB-first FNS encoder, modelling the upstream transmitter.
    function automatic logic [6:0] fns_enc(input int v);
        int         wt [0:6];
        int         rem;
        logic [6:0] c;
        wt  = '{1, 1, 2, 3, 5, 8, 13};
        rem = v;
        c   = 7'b0;
        for (int i = 6; i >= 0; i--) begin
            if (rem >= wt[i]) begin
                c[i] = 1'b1;
                rem  = rem - wt[i];
            end
        end
        return c;
    endfunction

    // Send one word from a negedge, check latency/result, hold, then drain.
    task automatic run_word(input logic [6:0] code, input logic [4:0] ed, input logic eo,
                            input int hold, input string nm);
        int lat;
        bit seen;
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        check({nm, " in_ready before send"}, in_ready, 1);
        code_in  = code;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        code_in  = 7'b0101010;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clock);
            if (out_valid) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({nm, " latency"}, lat, 8);
        check({nm, " data_out"}, data_out, ed);
        check({nm, " ovf"}, ovf, eo);
        check({nm, " in_ready during valid"}, in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check({nm, " held state"}, {in_ready, out_valid, ovf, data_out},
                  {1'b0, 1'b1, eo, ed});
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        check({nm, " out_valid after handshake"}, out_valid, 0);
        check({nm, " in_ready after handshake"}, in_ready, 1);
    endtask

    initial begin
        int acc_n [0:1];
        int acc_cnt;
        int ov_cnt;
        logic [4:0] ov_data [0:1];
        int ov_at [0:1];
        int stray;

        fns02 = 1'd1; fns03 = 2'd2; fns04 = 2'd3;
        fns05 = 3'd5; fns06 = 4'd8; fns07 = 4'd13;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; code_in = 7'b0;

        tbl[0] = '{7'b1000000, 5'd13, 1'b0};
        for (int v = 0; v <= 20; v++) tbl[v + 1] = '{fns_enc(v), 5'(v), 1'b0};
        tbl[22] = '{7'b1111111, 5'd1, 1'b1};

        repeat (3) @(negedge clock);
        check("reset outputs", {in_ready, out_valid, ovf, data_out}, 0);
        rst_n = 1'b1;
        #1;
        check("in_ready before first edge", in_ready, 0);
        @(negedge clock);
        check("in_ready after release", in_ready, 1);

        for (int i = 0; i <= 22; i++) begin
            run_word(tbl[i].code, tbl[i].exp_data, tbl[i].exp_ovf, 0, $sformatf("vec%0d", i));
        end

        // Backpressure: result and in_ready must not move while out_ready is low.
        run_word(7'b0000011, 5'd2, 1'b0, 20, "backpressure");

        // Asynchronous reset in the middle of an accumulation.
        @(negedge clock);
        code_in  = 7'b1111111;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {in_ready, out_valid, ovf, data_out}, 0);
        repeat (2) @(posedge clock);
        #1;
        check("outputs while in reset", {in_ready, out_valid, ovf, data_out}, 0);
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        check("in_ready right after release", in_ready, 0);
        @(posedge clock);
        #1;
        check("in_ready one edge after release", in_ready, 1);
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (out_valid) stray++;
        end
        check("discarded word not emitted", stray, 0);
        run_word(7'b0100100, 5'd10, 1'b0, 0, "post-reset word");

        // in_valid held high with a changing codeword: only T0 and T0+9 accept.
        acc_cnt = 0;
        ov_cnt  = 0;
        acc_n   = '{-1, -1};
        ov_at   = '{-1, -1};
        ov_data = '{5'd0, 5'd0};
        out_ready = 1'b1;
        for (int n = 0; n <= 17; n++) begin
            @(negedge clock);
            code_in  = (n == 0) ? 7'b1010101 : (n == 9) ? 7'b0100100 : 7'(n * 37 + 11);
            in_valid = 1'b1;
            if (in_ready) begin
                if (acc_cnt < 2) acc_n[acc_cnt] = n;
                acc_cnt++;
            end
            if (out_valid) begin
                if (ov_cnt < 2) begin
                    ov_at[ov_cnt]   = n;
                    ov_data[ov_cnt] = data_out;
                end
                ov_cnt++;
            end
        end
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("stream acceptance count", acc_cnt, 2);
        check("stream first acceptance", acc_n[0], 0);
        check("stream second acceptance", acc_n[1], 9);
        check("stream result count", ov_cnt, 2);
        check("stream first valid cycle", ov_at[0], 8);
        check("stream first data", ov_data[0], 21);
        check("stream second valid cycle", ov_at[1], 17);
        check("stream second data", ov_data[1], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
